// File: rtl/load_store_unit.sv
// Load/store unit: one memory request at a time between the execute stage and a
// single-ported data bus, with alignment checks, lane steering and a wait timeout.
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_cmd,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_xcpt_ma,
  output logic        resp_xcpt_af,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam logic [4:0] M_XRD       = 5'b00000;
  localparam logic [4:0] M_XWR       = 5'b00001;
  localparam logic [4:0] M_FLUSH_ALL = 5'b00101;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_REQ  = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       cmd_q, cmd_d;
  logic [2:0]       type_q, type_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             ma_q, ma_d;
  logic             af_q, af_d;

  // Unknown access types are handled like a full word.
  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    logic m;
    case (t)
      MT_B, MT_BU: m = 1'b0;
      MT_H, MT_HU: m = off[0];
      default:     m = (off != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] t, input logic [1:0] off);
    logic [3:0] be;
    case (t)
      MT_B, MT_BU: be = 4'b0001 << off;
      MT_H, MT_HU: be = 4'b0011 << off;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] t, input logic [31:0] wd);
    logic [31:0] d;
    case (t)
      MT_B, MT_BU: d = {4{wd[7:0]}};
      MT_H, MT_HU: d = {2{wd[15:0]}};
      default:     d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] t, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    b = rd[8*off +: 8];
    h = rd[16*off[1] +: 16];
    case (t)
      MT_B:    d = {{24{b[7]}}, b};
      MT_BU:   d = {24'd0, b};
      MT_H:    d = {{16{h[15]}}, h};
      MT_HU:   d = {16'd0, h};
      default: d = rd;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ma_d    = ma_q;
    af_d    = af_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d   = req_cmd;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          data_d  = '0;
          ma_d    = 1'b0;
          af_d    = 1'b0;
          cnt_d   = '0;
          if (req_cmd == M_FLUSH_ALL) begin
            state_d = S_RESP;
          end else if (req_cmd != M_XRD && req_cmd != M_XWR) begin
            af_d    = 1'b1;
            state_d = S_RESP;
          end else if (is_misaligned(req_type, req_addr[1:0])) begin
            ma_d    = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_MEM_REQ;
          end
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          state_d = S_MEM_WAIT;
          cnt_d   = '0;
        end
      end
      S_MEM_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the last allowed cycle beats the timeout.
        if (mem_resp_valid) begin
          state_d = S_RESP;
          if (cmd_q == M_XRD) begin
            data_d = extend_load(type_q, addr_q[1:0], mem_resp_rdata);
          end
        end else if (cnt_q == CNT_LAST) begin
          af_d    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ma_q    <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ma_q    <= ma_d;
      af_q    <= af_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_data    = resp_valid ? data_q : 32'd0;
  assign resp_xcpt_ma = resp_valid & ma_q;
  assign resp_xcpt_af = resp_valid & af_q;

  // Bus fields are held at zero whenever no request is being offered.
  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_we    = mem_req_valid & (cmd_q == M_XWR);
  assign mem_req_addr  = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_req_be    = mem_req_valid ? byte_enables(type_q, addr_q[1:0]) : 4'd0;
  assign mem_req_wdata = (mem_req_valid && cmd_q == M_XWR) ? lane_data(type_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: zero-wait accesses, alignment faults,
// stalled handshake, timeout, and reset during an outstanding access.
module tb_load_store_unit;

  localparam logic [4:0] M_XRD       = 5'b00000;
  localparam logic [4:0] M_XWR       = 5'b00001;
  localparam logic [4:0] M_FLUSH_ALL = 5'b00101;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_cmd;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_xcpt_ma;
  logic        resp_xcpt_af;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int errors = 0;
  int checks = 0;

  // Observations from the last run_access call.
  int          obs_cyc;
  logic        obs_saw_mem;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [31:0] obs_wdata;
  logic [31:0] obs_data;
  logic        obs_ma;
  logic        obs_af;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_xcpt_ma(resp_xcpt_ma), .resp_xcpt_af(resp_xcpt_af),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  // Issue one request against a zero-wait memory and record what happened.
  task automatic run_access(input logic [4:0] cmd, input logic [2:0] typ,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata);
    logic got, pending;
    got = 1'b0; pending = 1'b0;
    obs_cyc = 0; obs_saw_mem = 1'b0;
    obs_addr = '0; obs_be = '0; obs_we = 1'b0; obs_wdata = '0;
    obs_data = '0; obs_ma = 1'b0; obs_af = 1'b0;
    req_valid = 1'b1; req_cmd = cmd; req_type = typ; req_addr = addr; req_wdata = wdata;
    while (!got && obs_cyc < 20) begin
      @(posedge clk); #1;
      obs_cyc++;
      req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        obs_data = resp_data; obs_ma = resp_xcpt_ma; obs_af = resp_xcpt_af;
      end else if (mem_req_valid === 1'b1) begin
        if (!obs_saw_mem) begin
          obs_addr = mem_req_addr; obs_be = mem_req_be;
          obs_we = mem_req_we; obs_wdata = mem_req_wdata;
        end
        obs_saw_mem = 1'b1;
        mem_req_ready = 1'b1;
        pending = 1'b1;
      end else if (pending) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
        pending = 1'b0;
      end
    end
    if (!got) obs_cyc = -1;
    @(posedge clk); #1;
    $display("txn cmd=%0h type=%0d addr=%h -> cyc=%0d data=%h ma=%b af=%b",
             cmd, typ, addr, obs_cyc, obs_data, obs_ma, obs_af);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_xcpt_ma, resp_xcpt_af, mem_req_valid, mem_req_we} !== 6'b100000) begin
      errors++; $display("FAIL reset_flags: got %b expected 100000",
        {req_ready, resp_valid, resp_xcpt_ma, resp_xcpt_af, mem_req_valid, mem_req_we});
    end
    checks++;
    if ({resp_data, mem_req_addr, mem_req_wdata, mem_req_be} !== 100'd0) begin
      errors++; $display("FAIL reset_buses: data=%h addr=%h wdata=%h be=%b expected all 0",
        resp_data, mem_req_addr, mem_req_wdata, mem_req_be);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    $display("txn reset released");
  endtask

  task automatic test_lb();
    run_access(M_XRD, MT_B, 32'h0000_0103, 32'h0, 32'h80FF_1234);
    checks++;
    if (obs_addr !== 32'h100 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
      errors++; $display("FAIL lb_memreq: addr=%h be=%b we=%b expected 00000100 1000 0", obs_addr, obs_be, obs_we);
    end
    checks++;
    if (obs_data !== 32'hFFFF_FF80 || obs_ma !== 1'b0 || obs_af !== 1'b0) begin
      errors++; $display("FAIL lb_resp: data=%h ma=%b af=%b expected ffffff80 0 0", obs_data, obs_ma, obs_af);
    end
    checks++;
    if (obs_cyc !== 3) begin
      errors++; $display("FAIL lb_latency: got %0d expected 3", obs_cyc);
    end
  endtask

  task automatic test_half_loads();
    run_access(M_XRD, MT_HU, 32'h0000_0202, 32'h0, 32'h9ABC_0000);
    checks++;
    if (obs_be !== 4'b1100 || obs_data !== 32'h0000_9ABC) begin
      errors++; $display("FAIL lhu: be=%b data=%h expected 1100 00009abc", obs_be, obs_data);
    end
    run_access(M_XRD, MT_H, 32'h0000_0202, 32'h0, 32'h9ABC_0000);
    checks++;
    if (obs_data !== 32'hFFFF_9ABC) begin
      errors++; $display("FAIL lh: data=%h expected ffff9abc", obs_data);
    end
    run_access(M_XRD, MT_BU, 32'h0000_0102, 32'h0, 32'h80FF_1234);
    checks++;
    if (obs_be !== 4'b0100 || obs_data !== 32'h0000_00FF) begin
      errors++; $display("FAIL lbu: be=%b data=%h expected 0100 000000ff", obs_be, obs_data);
    end
  endtask

  task automatic test_stores();
    run_access(M_XWR, MT_B, 32'h0000_0041, 32'h1234_56A5, 32'hFFFF_FFFF);
    checks++;
    if (obs_wdata !== 32'hA5A5_A5A5 || obs_be !== 4'b0010 || obs_we !== 1'b1 || obs_addr !== 32'h40) begin
      errors++; $display("FAIL sb_memreq: wdata=%h be=%b we=%b addr=%h expected a5a5a5a5 0010 1 00000040",
        obs_wdata, obs_be, obs_we, obs_addr);
    end
    checks++;
    if (obs_data !== 32'h0 || obs_cyc !== 3) begin
      errors++; $display("FAIL sb_resp: data=%h cyc=%0d expected 0 3", obs_data, obs_cyc);
    end
    run_access(M_XWR, MT_H, 32'h0000_0042, 32'hDEAD_BEEF, 32'h0);
    checks++;
    if (obs_wdata !== 32'hBEEF_BEEF || obs_be !== 4'b1100) begin
      errors++; $display("FAIL sh_memreq: wdata=%h be=%b expected beefbeef 1100", obs_wdata, obs_be);
    end
    run_access(M_XWR, MT_W, 32'h0000_0048, 32'hCAFE_F00D, 32'h0);
    checks++;
    if (obs_wdata !== 32'hCAFE_F00D || obs_be !== 4'b1111) begin
      errors++; $display("FAIL sw_memreq: wdata=%h be=%b expected cafef00d 1111", obs_wdata, obs_be);
    end
  endtask

  task automatic test_misaligned();
    run_access(M_XRD, MT_W, 32'h0000_0006, 32'h0, 32'h1111_1111);
    checks++;
    if (obs_saw_mem !== 1'b0 || obs_cyc !== 1 || obs_ma !== 1'b1 || obs_af !== 1'b0 || obs_data !== 32'h0) begin
      errors++; $display("FAIL lw_misaligned: mem=%b cyc=%0d ma=%b af=%b data=%h expected 0 1 1 0 0",
        obs_saw_mem, obs_cyc, obs_ma, obs_af, obs_data);
    end
    run_access(M_XWR, MT_H, 32'h0000_0007, 32'h1234_5678, 32'h0);
    checks++;
    if (obs_saw_mem !== 1'b0 || obs_cyc !== 1 || obs_ma !== 1'b1 || obs_af !== 1'b0 || obs_data !== 32'h0) begin
      errors++; $display("FAIL sh_misaligned: mem=%b cyc=%0d ma=%b af=%b data=%h expected 0 1 1 0 0",
        obs_saw_mem, obs_cyc, obs_ma, obs_af, obs_data);
    end
    run_access(5'b00011, MT_W, 32'h0000_0010, 32'h0, 32'h0);
    checks++;
    if (obs_saw_mem !== 1'b0 || obs_cyc !== 1 || obs_af !== 1'b1 || obs_ma !== 1'b0) begin
      errors++; $display("FAIL illegal_cmd: mem=%b cyc=%0d af=%b ma=%b expected 0 1 1 0",
        obs_saw_mem, obs_cyc, obs_af, obs_ma);
    end
  endtask

  // Stall the handshake for five cycles, then either let the wait expire or
  // respond in the last wait cycle.
  task automatic test_timeout(input logic respond_last);
    logic stable;
    int   c;
    req_valid = 1'b1; req_cmd = M_XRD; req_type = MT_W; req_addr = 32'h10; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'h10 && mem_req_be === 4'hF && mem_req_we === 1'b0))
        stable = 1'b0;
      if (i == 4) mem_req_ready = 1'b1;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    checks++;
    if (stable !== 1'b1) begin
      errors++; $display("FAIL stall_stable: got %b expected 1", stable);
    end
    c = 0;
    while (resp_valid !== 1'b1 && c < 10) begin
      if (respond_last && c == 3) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55AA_1234;
      end
      @(posedge clk); #1;
      mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      c++;
    end
    checks++;
    if (c !== 4) begin
      errors++; $display("FAIL wait_len(resp=%b): got %0d expected 4", respond_last, c);
    end
    checks++;
    if (respond_last) begin
      if (resp_xcpt_af !== 1'b0 || resp_data !== 32'h55AA_1234) begin
        errors++; $display("FAIL late_resp: af=%b data=%h expected 0 55aa1234", resp_xcpt_af, resp_data);
      end
    end else begin
      if (resp_xcpt_af !== 1'b1 || resp_xcpt_ma !== 1'b0 || resp_data !== 32'h0) begin
        errors++; $display("FAIL timeout_af: af=%b ma=%b data=%h expected 1 0 0", resp_xcpt_af, resp_xcpt_ma, resp_data);
      end
    end
    @(posedge clk); #1;
    $display("txn stalled lw respond_last=%b -> wait=%0d af=%b", respond_last, c, resp_xcpt_af);
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    req_valid = 1'b1; req_cmd = M_XRD; req_type = MT_W; req_addr = 32'h20; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    checks++;
    if ({req_ready, resp_valid, resp_xcpt_ma, resp_xcpt_af, mem_req_valid, mem_req_we} !== 6'b100000 ||
        resp_data !== 32'h0 || mem_req_addr !== 32'h0 || mem_req_be !== 4'h0 || mem_req_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_abandon: ready=%b rv=%b data=%h addr=%h expected 1 0 0 0",
        req_ready, resp_valid, resp_data, mem_req_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL no_stale_resp: got %b expected 0", seen);
    end
    $display("txn reset during MEM_WAIT, late response dropped");
    run_access(M_FLUSH_ALL, MT_W, 32'h0, 32'h0, 32'h0);
    checks++;
    if (obs_cyc !== 1 || obs_saw_mem !== 1'b0 || obs_ma !== 1'b0 || obs_af !== 1'b0 || obs_data !== 32'h0) begin
      errors++; $display("FAIL flush: cyc=%0d mem=%b ma=%b af=%b data=%h expected 1 0 0 0 0",
        obs_cyc, obs_saw_mem, obs_ma, obs_af, obs_data);
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_cmd = '0; req_type = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    test_reset();
    test_lb();
    test_half_loads();
    test_stores();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the decoder's memory control fields (mem, mem_cmd, mem_mask_type).
- Sits between the execute stage and the single-ported data memory bus.
- Accepts one load, store or flush request at a time, checks alignment, drives a word-aligned memory transaction with byte enables, and returns sign- or zero-extended load data or an exception flag to the pipeline.
- A per-access timeout converts a hung memory into an access fault.

Parameters:
- TIMEOUT, 255: maximum cycles spent in MEM_WAIT before an access fault is raised; must be ≥1.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory request.
- req_ready  out  1  unit accepts the request this cycle.
- req_cmd  in  Bundle M_* width  M_XRD, M_XWR or M_FLUSH_ALL; any other value is illegal.
- req_type  in  Bundle MT_* width  MT_B, MT_H, MT_W, MT_BU or MT_HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  single-cycle completion pulse.
- resp_data  out  32  extended load data; 0 for stores, flushes and exceptions.
- resp_xcpt_ma  out  1  misaligned-access exception; valid with resp_valid.
- resp_xcpt_af  out  1  access fault (timeout or illegal cmd); valid with resp_valid.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_req_be  out  4  byte enables.
- mem_req_wdata  out  32  lane-replicated store data.
- mem_resp_valid  in  1  read data or write acknowledge.
- mem_resp_rdata  in  32  read word.

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready = 1; timeout counter 0; registered request fields 0.
- Reset mid-transaction abandons the access immediately. A late mem_resp_valid that arrives in IDLE is ignored.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, register cmd, type, addr and wdata.
  - M_FLUSH_ALL goes to RESP with no memory access and no exception.
  - An illegal cmd goes to RESP with af = 1.
  - A misaligned access goes to RESP with ma = 1 and no memory access. Misaligned means H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
  - All other requests go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid = 1 with stable fields until mem_req_ready, then go to MEM_WAIT and clear the counter.
  - No timeout applies in this state.
  - mem_resp_valid is ignored here.
- MEM_WAIT:
  - The counter increments each cycle.
  - On mem_resp_valid, capture rdata (loads) and go to RESP.
  - If the counter reaches TIMEOUT without mem_resp_valid, go to RESP with af = 1.
  - If mem_resp_valid and the timeout occur in the same cycle, the response wins and af = 0.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready = 0 in every state except IDLE.
  - There is no resp backpressure.
- Byte enables, with off = addr[1:0]:
  - B/BU: 4'b0001 << off.
  - H/HU: 4'b0011 << off.
  - W: 4'b1111.
- Store data lanes:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata unchanged.
- Load extraction: byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16].
  - MT_B and MT_H sign-extend.
  - MT_BU and MT_HU zero-extend.
  - MT_W passes the word through.
- Latency with a zero-wait memory (ready on the first MEM_REQ cycle, resp the cycle after): accept at cycle 0, resp_valid at cycle 3. The flush/exception path gives resp_valid at cycle 1.
- The earliest legal mem_resp_valid is one cycle after the handshake.

Test Plan:
- LB at addr 0x103, memory returns 0x80FF_1234 → mem_req_addr 0x100, be 4'b1000, we 0; resp_data 0xFFFF_FF80, flags 0, resp_valid 3 cycles after accept.
- LHU at 0x202, rdata 0x9ABC_0000 → be 4'b1100, resp_data 0x0000_9ABC. LH at the same address with the same rdata → 0xFFFF_9ABC.
- SB at 0x41, wdata 0x1234_56A5 → mem_req_wdata 0xA5A5_A5A5, be 4'b0010, we 1; resp_data 0 after the ack.
- LW at 0x06 → no mem_req_valid, resp_valid the next cycle, ma = 1, resp_data 0. SH at 0x07 gives the same response.
- LW with mem_req_ready held 0 for 5 cycles, then memory never responds (TIMEOUT = 4) → mem_req fields stable for 5 cycles; resp_valid with af = 1 four cycles after entering MEM_WAIT. mem_resp_valid asserted in the final wait cycle → af = 0 with the data returned.
- reset asserted during MEM_WAIT, then mem_resp_valid arrives → the next cycle shows req_ready = 1 and all other outputs 0, and no resp_valid is ever produced for the abandoned access. M_FLUSH_ALL afterwards → resp_valid 1 cycle later, flags 0.
